mult_error_monitor: RTL and testbench



---
 rtl/mult_eval_pkg.sv | 22 ++
 rtl/ed_stage.sv | 51 +++++
 rtl/mult_error_monitor.sv | 150 +++++++++++++++
 tb/tb_mult_error_monitor.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_eval_pkg.sv
// Shared constants and state encoding for the approximate-multiplier error monitor.
package mult_eval_pkg;

    localparam int W_DEF       = 16;
    localparam int CNT_W_DEF   = 17;
    localparam int SAMPLES_DEF = 65536;

    // Accumulators need one sign bit plus headroom for CNT_W additions of a W+1-bit value.
    function automatic int acc_width(input int w, input int cnt_w);
        return w + cnt_w + 1;
    endfunction

    localparam int ACC_W_DEF = acc_width(W_DEF, CNT_W_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/ed_stage.sv
// Stage 1: registers the signed error distance, its magnitude and a mismatch flag for one pair.
module ed_stage #(
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                load,
    input  logic [W-1:0]        exact,
    input  logic [W-1:0]        apprx,
    output logic                vld_r,
    output logic signed [W:0]   diff_r,
    output logic [W-1:0]        abs_r,
    output logic                mismatch_r
);

    logic [W:0]   diff_s;
    logic [W:0]   neg_s;
    logic [W-1:0] abs_s;

    // Both subtraction orders are formed so the magnitude never needs a W+1-bit negate.
    always_comb begin
        diff_s = {1'b0, exact} - {1'b0, apprx};
        neg_s  = {1'b0, apprx} - {1'b0, exact};
        if (diff_s[W]) begin
            abs_s = neg_s[W-1:0];
        end else begin
            abs_s = diff_s[W-1:0];
        end
    end

    // Pipeline register; a flush only kills the valid bit, the payload is don't-care.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r      <= 1'b0;
            diff_r     <= '0;
            abs_r      <= '0;
            mismatch_r <= 1'b0;
        end else if (flush) begin
            vld_r      <= 1'b0;
        end else if (load) begin
            vld_r      <= 1'b1;
            diff_r     <= $signed(diff_s);
            abs_r      <= abs_s;
            mismatch_r <= (exact != apprx);
        end else begin
            vld_r      <= 1'b0;
        end
    end

endmodule

// File: rtl/mult_error_monitor.sv
// Error-statistics engine for an approximate multiplier: run FSM plus stage-2 accumulators.
module mult_error_monitor
    import mult_eval_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int SAMPLES = SAMPLES_DEF,
    parameter int ACC_W   = W + CNT_W + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W-1:0]            exact,
    input  logic [W-1:0]            apprx,
    output logic [CNT_W-1:0]        sample_cnt,
    output logic [CNT_W-1:0]        err_cnt,
    output logic signed [ACC_W-1:0] sum_ed,
    output logic [ACC_W-1:0]        sum_abs_ed,
    output logic [W-1:0]            max_ed,
    output logic                    busy,
    output logic                    done
);

    state_e                  state_r;
    state_e                  state_s;
    logic                    in_ready_r;
    logic                    busy_r;
    logic                    done_r;
    logic [CNT_W-1:0]        sample_cnt_r;
    logic [CNT_W-1:0]        sample_cnt_s;
    logic [CNT_W-1:0]        err_cnt_r;
    logic signed [ACC_W-1:0] sum_ed_r;
    logic [ACC_W-1:0]        sum_abs_r;
    logic [W-1:0]            max_ed_r;
    logic                    xfer_s;
    logic                    load_s;
    logic                    st_vld_r;
    logic signed [W:0]       st_diff_r;
    logic [W-1:0]            st_abs_r;
    logic                    st_mismatch_r;

    ed_stage #(.W(W)) u_ed_stage (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (start),
        .load       (load_s),
        .exact      (exact),
        .apprx      (apprx),
        .vld_r      (st_vld_r),
        .diff_r     (st_diff_r),
        .abs_r      (st_abs_r),
        .mismatch_r (st_mismatch_r)
    );

    // Transfer qualification, next sample count and next state; start always wins.
    always_comb begin
        xfer_s       = in_valid && in_ready_r;
        load_s       = xfer_s && !start;
        sample_cnt_s = sample_cnt_r;
        state_s      = state_r;
        if (start) begin
            sample_cnt_s = '0;
        end else if (xfer_s) begin
            sample_cnt_s = sample_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            sample_cnt_s = sample_cnt_r;
        end
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = state_r;
                end
            end
            RUN: begin
                if (start) begin
                    state_s = RUN;
                end else if (xfer_s && (sample_cnt_s == CNT_W'(SAMPLES))) begin
                    state_s = DRAIN;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN: begin
                if (start) begin
                    state_s = RUN;
                end else if (!st_vld_r) begin
                    state_s = DONE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, sample counter and handshake/status flags, all derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            sample_cnt_r <= '0;
            in_ready_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            sample_cnt_r <= sample_cnt_s;
            in_ready_r   <= (state_s == RUN) && (sample_cnt_s < CNT_W'(SAMPLES));
            busy_r       <= (state_s == RUN) || (state_s == DRAIN);
            done_r       <= (state_s == DONE);
        end
    end

    // Stage 2 accumulation; ties on the maximum leave max_ed untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r <= '0;
            sum_ed_r  <= '0;
            sum_abs_r <= '0;
            max_ed_r  <= '0;
        end else if (start) begin
            err_cnt_r <= '0;
            sum_ed_r  <= '0;
            sum_abs_r <= '0;
            max_ed_r  <= '0;
        end else if (st_vld_r) begin
            err_cnt_r <= err_cnt_r + {{(CNT_W-1){1'b0}}, st_mismatch_r};
            sum_ed_r  <= sum_ed_r + {{(ACC_W-W-1){st_diff_r[W]}}, st_diff_r};
            sum_abs_r <= sum_abs_r + {{(ACC_W-W){1'b0}}, st_abs_r};
            if (st_abs_r > max_ed_r) begin
                max_ed_r <= st_abs_r;
            end
        end
    end

    assign in_ready   = in_ready_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign sample_cnt = sample_cnt_r;
    assign err_cnt    = err_cnt_r;
    assign sum_ed     = sum_ed_r;
    assign sum_abs_ed = sum_abs_r;
    assign max_ed     = max_ed_r;

endmodule

// File: tb/tb_mult_error_monitor.sv
// Scoreboard bench: stimulus queues expected run totals, a monitor compares them when done rises.
module tb_mult_error_monitor;

    localparam int W     = 16;
    localparam int CNT_W = 17;
    localparam int ACC_W = 34;

    typedef struct {
        longint sc;
        longint ec;
        longint se;
        longint sa;
        longint mx;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    exp_t sq[$];
    exp_t lq[$];

    // Small instance (4 samples per run)
    logic                    s_start = 1'b0, s_in_valid = 1'b0, s_in_ready, s_busy, s_done;
    logic [W-1:0]            s_exact = '0, s_apprx = '0, s_max_ed;
    logic [CNT_W-1:0]        s_sample_cnt, s_err_cnt;
    logic signed [ACC_W-1:0] s_sum_ed;
    logic [ACC_W-1:0]        s_sum_abs_ed;
    logic                    s_done_q = 1'b0;

    // Default instance (65536 samples per run)
    logic                    l_start = 1'b0, l_in_valid = 1'b0, l_in_ready, l_busy, l_done;
    logic [W-1:0]            l_exact = '0, l_apprx = '0, l_max_ed;
    logic [CNT_W-1:0]        l_sample_cnt, l_err_cnt;
    logic signed [ACC_W-1:0] l_sum_ed;
    logic [ACC_W-1:0]        l_sum_abs_ed;
    logic                    l_done_q = 1'b0;

    mult_error_monitor #(.W(W), .CNT_W(CNT_W), .SAMPLES(4), .ACC_W(ACC_W)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .exact(s_exact), .apprx(s_apprx), .sample_cnt(s_sample_cnt), .err_cnt(s_err_cnt),
        .sum_ed(s_sum_ed), .sum_abs_ed(s_sum_abs_ed), .max_ed(s_max_ed), .busy(s_busy), .done(s_done)
    );

    mult_error_monitor dut_l (
        .clk(clk), .rst_n(rst_n), .start(l_start), .in_valid(l_in_valid), .in_ready(l_in_ready),
        .exact(l_exact), .apprx(l_apprx), .sample_cnt(l_sample_cnt), .err_cnt(l_err_cnt),
        .sum_ed(l_sum_ed), .sum_abs_ed(l_sum_abs_ed), .max_ed(l_max_ed), .busy(l_busy), .done(l_done)
    );

    task automatic chk(input string nm, input logic signed [63:0] act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic cmp_run(input string p, input exp_t e, input logic [CNT_W-1:0] sc,
                           input logic [CNT_W-1:0] ec, input logic signed [ACC_W-1:0] se,
                           input logic [ACC_W-1:0] sa, input logic [W-1:0] mx);
        chk({p, "_sample_cnt"}, sc, e.sc);
        chk({p, "_err_cnt"}, ec, e.ec);
        chk({p, "_sum_ed"}, se, e.se);
        chk({p, "_sum_abs_ed"}, sa, e.sa);
        chk({p, "_max_ed"}, mx, e.mx);
    endtask

    // Monitor: on each rising done, pop the oldest expected run and compare the totals.
    always @(negedge clk) begin
        s_done_q <= s_done;
        l_done_q <= l_done;
        if (s_done && !s_done_q) begin
            if (sq.size() == 0) begin
                chk("s_unexpected_done", 1, 0);
            end else begin
                cmp_run("s_run", sq.pop_front(), s_sample_cnt, s_err_cnt, s_sum_ed, s_sum_abs_ed, s_max_ed);
            end
        end
        if (l_done && !l_done_q) begin
            if (lq.size() == 0) begin
                chk("l_unexpected_done", 1, 0);
            end else begin
                cmp_run("l_run", lq.pop_front(), l_sample_cnt, l_err_cnt, l_sum_ed, l_sum_abs_ed, l_max_ed);
            end
        end
    end

    task automatic s_start_pulse();
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
    endtask

    task automatic s_send(input int e, input int a);
        int guard = 0;
        while (s_in_ready !== 1'b1 && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        chk("s_ready_before_send", s_in_ready, 1);
        s_in_valid = 1'b1;
        s_exact = e[15:0];
        s_apprx = a[15:0];
        @(negedge clk);
        s_in_valid = 1'b0;
    endtask

    task automatic s_wait_done();
        int guard = 0;
        while (s_done !== 1'b1 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        chk("s_done_timeout", s_done, 1);
    endtask

    int t1_e[4] = '{100, 200, 50, 0};
    int t1_a[4] = '{100, 196, 58, 0};
    int t1_lag[4] = '{0, 0, 4, 12};
    int t2_e[4] = '{7, 3, 1000, 255};
    int t2_a[4] = '{3, 7, 1000, 0};
    int t3_e[4] = '{65535, 0, 0, 7};
    int t3_a[4] = '{0, 65535, 0, 7};

    initial begin
        logic [15:0] iv;
        int guard;

        // Reset state
        @(negedge clk);
        chk("s_rst_in_ready", s_in_ready, 0);
        chk("s_rst_busy", s_busy, 0);
        chk("s_rst_done", s_done, 0);
        cmp_run("s_rst", '{0, 0, 0, 0, 0}, s_sample_cnt, s_err_cnt, s_sum_ed, s_sum_abs_ed, s_max_ed);
        chk("l_rst_in_ready", l_in_ready, 0);
        chk("l_rst_done", l_done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("s_idle_in_ready", s_in_ready, 0);
        chk("s_idle_busy", s_busy, 0);

        // Basic 4-pair run with stage-2 latency and done timing
        s_start_pulse();
        chk("s_start_in_ready", s_in_ready, 1);
        chk("s_start_busy", s_busy, 1);
        sq.push_back('{4, 2, -4, 12, 8});
        for (int i = 0; i < 4; i++) begin
            s_send(t1_e[i], t1_a[i]);
            chk("t1_sample_cnt", s_sample_cnt, i + 1);
            chk("t1_sum_abs_lag", s_sum_abs_ed, t1_lag[i]);
        end
        chk("t1_ready_drop", s_in_ready, 0);
        chk("t1_done_edge0", s_done, 0);
        @(negedge clk);
        chk("t1_done_edge1", s_done, 0);
        chk("t1_err_final", s_err_cnt, 2);
        chk("t1_sum_ed_final", s_sum_ed, -4);
        @(negedge clk);
        chk("t1_done_edge2", s_done, 1);
        chk("t1_busy_done", s_busy, 0);
        s_in_valid = 1'b1;
        s_exact = 16'd1;
        s_apprx = 16'd2;
        @(negedge clk);
        s_in_valid = 1'b0;
        chk("t1_frozen_cnt", s_sample_cnt, 4);
        chk("t1_frozen_err", s_err_cnt, 2);

        // in_valid toggled every other cycle, garbage on idle cycles
        s_start_pulse();
        chk("t2_cleared_done", s_done, 0);
        chk("t2_cleared_max", s_max_ed, 0);
        sq.push_back('{4, 3, 255, 263, 255});
        for (int i = 0; i < 4; i++) begin
            s_in_valid = 1'b1;
            s_exact = t2_e[i][15:0];
            s_apprx = t2_a[i][15:0];
            @(negedge clk);
            if (i < 3) begin
                s_in_valid = 1'b0;
                s_exact = 16'hFFFF;
                s_apprx = 16'h0000;
                @(negedge clk);
            end
        end
        s_in_valid = 1'b0;
        chk("t2_done_edge0", s_done, 0);
        @(negedge clk);
        chk("t2_done_edge1", s_done, 0);
        @(negedge clk);
        chk("t2_done_edge2", s_done, 1);

        // Extremes
        s_start_pulse();
        sq.push_back('{4, 2, 0, 131070, 65535});
        for (int i = 0; i < 4; i++) s_send(t3_e[i], t3_a[i]);
        s_wait_done();

        // Abort mid-run on a transfer cycle
        s_start_pulse();
        s_send(10, 20);
        s_send(30, 30);
        chk("t4_pre_err", s_err_cnt, 1);
        chk("t4_pre_sum_ed", s_sum_ed, -10);
        s_in_valid = 1'b1;
        s_exact = 16'd5;
        s_apprx = 16'd1;
        s_start = 1'b1;
        @(negedge clk);
        s_in_valid = 1'b0;
        s_start = 1'b0;
        cmp_run("t4_cleared", '{0, 0, 0, 0, 0}, s_sample_cnt, s_err_cnt, s_sum_ed, s_sum_abs_ed, s_max_ed);
        chk("t4_ready", s_in_ready, 1);
        @(negedge clk);
        chk("t4_flushed_err", s_err_cnt, 0);
        chk("t4_flushed_abs", s_sum_abs_ed, 0);
        sq.push_back('{4, 2, -4, 12, 8});
        for (int i = 0; i < 4; i++) s_send(t1_e[i], t1_a[i]);
        s_wait_done();

        // Full default run against an exact multiplier, no bubbles
        l_start = 1'b1;
        @(negedge clk);
        l_start = 1'b0;
        lq.push_back('{65536, 0, 0, 0, 0});
        for (int i = 0; i < 65536; i++) begin
            iv = i[15:0];
            l_in_valid = 1'b1;
            l_exact = 16'(iv[7:0]) * 16'(iv[15:8]);
            l_apprx = 16'(iv[7:0]) * 16'(iv[15:8]);
            @(negedge clk);
        end
        l_in_valid = 1'b0;
        chk("l_full_cnt", l_sample_cnt, 65536);
        chk("l_full_ready_drop", l_in_ready, 0);
        guard = 0;
        while (l_done !== 1'b1 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        chk("l_done_timeout", l_done, 1);

        // Asynchronous reset mid-run
        l_start = 1'b1;
        @(negedge clk);
        l_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            l_in_valid = 1'b1;
            l_exact = 16'(i + 100);
            l_apprx = 16'(i);
            @(negedge clk);
        end
        chk("l_mid_cnt", l_sample_cnt, 10);
        chk("l_mid_err", l_err_cnt, 9);
        #2;
        rst_n = 1'b0;
        #1;
        cmp_run("l_async_rst", '{0, 0, 0, 0, 0}, l_sample_cnt, l_err_cnt, l_sum_ed, l_sum_abs_ed, l_max_ed);
        chk("l_async_rst_ready", l_in_ready, 0);
        chk("l_async_rst_busy", l_busy, 0);
        chk("l_async_rst_done", l_done, 0);
        @(negedge clk);
        l_in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("l_post_rst_ready", l_in_ready, 0);
        chk("l_post_rst_busy", l_busy, 0);

        chk("s_scoreboard_empty", sq.size(), 0);
        chk("l_scoreboard_empty", lq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
